lfsr_nd_7seg_display: RTL and testbench

- Parametrised successor to the single-digit LFSR/7-segment top.
- A configurable-width Fibonacci LFSR drives an N-digit multiplexed hex display.
- Everything runs on one clock; the derived slow clock is replaced by clock-enable ticks.
- Adds seed load, single-step, display hold and leading-zero blanking.
- Instantiated at board top level, with the clock from the 10 MHz oscillator.

---
 rtl/lfsr_nd_7seg_display.sv | 147 ++++++++++++++
 tb/tb_lfsr_nd_7seg_display.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_nd_7seg_display.sv
// Fibonacci LFSR with seed load, single-step and an N-digit multiplexed hex display.
// Single clock domain; step and scan rates come from clock-enable counters.
module lfsr_nd_7seg_display #(
  parameter int                    LFSR_WIDTH = 16,
  parameter logic [LFSR_WIDTH-1:0] TAPS       = 16'hB400,
  parameter logic [LFSR_WIDTH-1:0] SEED       = 16'hACE1,
  parameter int                    NUM_DIGITS = 4,
  parameter int                    STEP_DIV   = 10_000_000,
  parameter int                    SCAN_DIV   = 10_000,
  parameter bit                    BLANK_LZ   = 1'b0
) (
  input  logic                  clock_10Mhz,
  input  logic                  reset,
  input  logic                  i_enable,
  input  logic                  i_step,
  input  logic                  i_load,
  input  logic [LFSR_WIDTH-1:0] i_seed,
  input  logic                  i_hold,
  output logic [LFSR_WIDTH-1:0] o_lfsr,
  output logic                  o_step_tick,
  output logic [NUM_DIGITS-1:0] Anode_Activate,
  output logic [6:0]            LED_out
);

  localparam int DW4 = NUM_DIGITS * 4;
  localparam int STW = $clog2(STEP_DIV);
  localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [STW-1:0] STEP_LAST = STW'(STEP_DIV - 1);
  localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);
  localparam logic [IDW-1:0] IDX_LAST  = IDW'(NUM_DIGITS - 1);

  logic [STW-1:0]        step_cnt;
  logic                  step_q;
  logic                  advance;
  logic [LFSR_WIDTH-1:0] lfsr_next;
  logic [SCW-1:0]        scan_cnt;
  logic [IDW-1:0]        digit_idx;
  logic [DW4-1:0]        disp_latch;
  logic [DW4-1:0]        lfsr_ext;
  logic [NUM_DIGITS-1:0] zero_from;
  logic [NUM_DIGITS-1:0] anode_nxt;
  logic [3:0]            cur_nib;
  logic                  cur_blank;
  logic                  zero_acc;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'b0000001;
      4'h1: hex_to_seg = 7'b1001111;
      4'h2: hex_to_seg = 7'b0010010;
      4'h3: hex_to_seg = 7'b0000110;
      4'h4: hex_to_seg = 7'b1001100;
      4'h5: hex_to_seg = 7'b0100100;
      4'h6: hex_to_seg = 7'b0100000;
      4'h7: hex_to_seg = 7'b0001111;
      4'h8: hex_to_seg = 7'b0000000;
      4'h9: hex_to_seg = 7'b0000100;
      4'hA: hex_to_seg = 7'b0001000;
      4'hB: hex_to_seg = 7'b1100000;
      4'hC: hex_to_seg = 7'b0110001;
      4'hD: hex_to_seg = 7'b1000010;
      4'hE: hex_to_seg = 7'b0110000;
      default: hex_to_seg = 7'b0111000;
    endcase
  endfunction

  // Auto stepping and manual edges are mutually exclusive through i_enable.
  assign advance   = i_enable ? (step_cnt == STEP_LAST) : (i_step & ~step_q);
  assign lfsr_next = {o_lfsr[LFSR_WIDTH-2:0], ^(o_lfsr & TAPS)};

  always_ff @(posedge clock_10Mhz) begin
    if (reset) begin
      step_cnt    <= '0;
      step_q      <= 1'b0;
      o_lfsr      <= SEED;
      o_step_tick <= 1'b0;
    end else begin
      step_q <= i_step;
      if (!i_enable || step_cnt == STEP_LAST) step_cnt <= '0;
      else                                    step_cnt <= step_cnt + 1'b1;
      o_step_tick <= 1'b0;
      // A zero seed would lock the register, so it is replaced by SEED.
      if (i_load) o_lfsr <= (i_seed == '0) ? SEED : i_seed;
      else if (advance) begin
        o_lfsr      <= lfsr_next;
        o_step_tick <= 1'b1;
      end
    end
  end

  generate
    if (LFSR_WIDTH >= DW4) begin : g_trunc
      assign lfsr_ext = o_lfsr[DW4-1:0];
    end else begin : g_ext
      assign lfsr_ext = {{(DW4-LFSR_WIDTH){1'b0}}, o_lfsr};
    end
  endgenerate

  always_ff @(posedge clock_10Mhz) begin
    if (reset) begin
      scan_cnt   <= '0;
      digit_idx  <= '0;
      disp_latch <= '0;
    end else begin
      if (!i_hold) disp_latch <= lfsr_ext;
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt  <= '0;
        digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

  // zero_from[d] is set when nibbles d..top are all zero.
  always_comb begin
    zero_from = '0;
    anode_nxt = '1;
    cur_nib   = 4'h0;
    cur_blank = 1'b0;
    zero_acc  = 1'b1;
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      zero_acc     = zero_acc & (disp_latch[d*4 +: 4] == 4'h0);
      zero_from[d] = zero_acc;
    end
    for (int d = 0; d < NUM_DIGITS; d++) begin
      anode_nxt[d] = (digit_idx != IDW'(d));
      if (digit_idx == IDW'(d)) begin
        cur_nib   = disp_latch[d*4 +: 4];
        cur_blank = BLANK_LZ && (d != 0) && zero_from[d];
      end
    end
  end

  always_ff @(posedge clock_10Mhz) begin
    if (reset) begin
      Anode_Activate <= '1;
      LED_out        <= 7'b1111111;
    end else begin
      Anode_Activate <= anode_nxt;
      LED_out        <= cur_blank ? 7'b1111111 : hex_to_seg(cur_nib);
    end
  end

endmodule

// File: tb/tb_lfsr_nd_7seg_display.sv
// Bench for lfsr_nd_7seg_display: directed steps plus random stimulus against a
// cycle-level reference model; a narrow 1-digit instance checks the full LFSR period.
`timescale 1ns/1ps
module tb_lfsr_nd_7seg_display;

  localparam int          STEP_DIV = 4;
  localparam int          SCAN_DIV = 2;
  localparam logic [15:0] SEED     = 16'hACE1;
  localparam logic [15:0] TAPS     = 16'hB400;

  logic clk = 1'b0;
  always #50 clk = ~clk;

  logic        reset = 1'b1, i_enable = 1'b0, i_step = 1'b0, i_load = 1'b0, i_hold = 1'b0;
  logic [15:0] i_seed = 16'h0;
  logic [15:0] o_lfsr, lfsr_b;
  logic        o_step_tick, tick_b;
  logic [3:0]  anode, anode_b;
  logic [6:0]  led, led_b;

  logic        p_reset = 1'b1, p_enable = 1'b1, p_zero = 1'b0;
  logic [7:0]  p_seed = 8'h00;
  logic [7:0]  p_lfsr;
  logic        p_tick;
  logic [0:0]  p_anode;
  logic [6:0]  p_led;

  lfsr_nd_7seg_display #(.STEP_DIV(STEP_DIV), .SCAN_DIV(SCAN_DIV)) dut (
    .clock_10Mhz(clk), .reset(reset), .i_enable(i_enable), .i_step(i_step),
    .i_load(i_load), .i_seed(i_seed), .i_hold(i_hold), .o_lfsr(o_lfsr),
    .o_step_tick(o_step_tick), .Anode_Activate(anode), .LED_out(led));

  lfsr_nd_7seg_display #(.STEP_DIV(STEP_DIV), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b1)) dut_b (
    .clock_10Mhz(clk), .reset(reset), .i_enable(i_enable), .i_step(i_step),
    .i_load(i_load), .i_seed(i_seed), .i_hold(i_hold), .o_lfsr(lfsr_b),
    .o_step_tick(tick_b), .Anode_Activate(anode_b), .LED_out(led_b));

  lfsr_nd_7seg_display #(.LFSR_WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .NUM_DIGITS(1),
                         .STEP_DIV(2), .SCAN_DIV(1)) dut_p (
    .clock_10Mhz(clk), .reset(p_reset), .i_enable(p_enable), .i_step(p_zero),
    .i_load(p_zero), .i_seed(p_seed), .i_hold(p_zero), .o_lfsr(p_lfsr),
    .o_step_tick(p_tick), .Anode_Activate(p_anode), .LED_out(p_led));

  logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  logic [6:0] exp_seg   [4] = '{7'b0100100, 7'b0001000, 7'b0000001, 7'b0000001};
  logic [6:0] exp_seg_b [4] = '{7'b0100100, 7'b0001000, 7'b1111111, 7'b1111111};

  int n_vec = 0, n_err = 0, n_ticks = 0;

  // Reference state: what each registered output should hold after the latest edge.
  logic [15:0] m_lfsr, m_latch;
  logic        m_tick, m_prev;
  logic [3:0]  m_anode;
  logic [6:0]  m_led, m_led_b;
  int          m_cnt, m_scan, m_idx;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s, input logic [31:0] taps,
                                            input int w);
    int ones = 0;
    for (int i = 0; i < w; i++) if (s[i] && taps[i]) ones++;
    return ((s << 1) | 32'(ones % 2)) & ((32'h1 << w) - 32'h1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    logic        adv;
    logic [15:0] upper;
    logic [3:0]  nib;
    if (reset) begin
      m_lfsr = SEED; m_tick = 1'b0; m_prev = 1'b0; m_latch = 16'h0;
      m_cnt = 0; m_scan = 0; m_idx = 0;
      m_anode = 4'hF; m_led = 7'h7F; m_led_b = 7'h7F;
    end else begin
      upper   = m_latch >> (4 * m_idx);
      nib     = upper[3:0];
      m_anode = ~(4'b0001 << m_idx);
      m_led   = seg_tab[nib];
      m_led_b = (m_idx > 0 && upper == 16'h0) ? 7'h7F : seg_tab[nib];
      adv     = i_enable ? (m_cnt == STEP_DIV - 1) : (i_step && !m_prev);
      if (!i_hold) m_latch = m_lfsr;
      m_tick = 1'b0;
      if (i_load) m_lfsr = (i_seed == 16'h0) ? SEED : i_seed;
      else if (adv) begin
        m_lfsr = 16'(lfsr_next(32'(m_lfsr), 32'(TAPS), 16));
        m_tick = 1'b1;
      end
      m_cnt  = i_enable ? (m_cnt + 1) % STEP_DIV : 0;
      m_prev = i_step;
      if (m_scan == SCAN_DIV - 1) begin
        m_scan = 0;
        m_idx  = (m_idx + 1) % 4;
      end else m_scan++;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    if (o_step_tick === 1'b1) n_ticks++;
    chk("lfsr", 32'(o_lfsr), 32'(m_lfsr));
    chk("tick", 32'(o_step_tick), 32'(m_tick));
    chk("anode", 32'(anode), 32'(m_anode));
    chk("led", 32'(led), 32'(m_led));
    chk("lfsr_blank_inst", 32'(lfsr_b), 32'(m_lfsr));
    chk("led_blank", 32'(led_b), 32'(m_led_b));
  endtask

  initial begin
    int          t0, steps, visits [4], found;
    logic [7:0]  p_prev, ph1, ph2;
    bit          done;

    // Reset state
    repeat (3) cycle();
    chk("rst_lfsr", 32'(o_lfsr), 32'hACE1);
    chk("rst_anode", 32'(anode), 32'hF);
    chk("rst_led", 32'(led), 32'h7F);

    // Auto stepping cadence and first value
    reset = 1'b0; i_enable = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      chk("tick_cadence", 32'(o_step_tick), (k % 4 == 0) ? 32'h1 : 32'h0);
      if (k == 4) chk("first_step", 32'(o_lfsr), 32'h59C3);
    end

    // Manual single step
    i_enable = 1'b0;
    repeat (2) cycle();
    t0 = n_ticks;
    repeat (3) begin
      i_step = 1'b1; cycle();
      i_step = 1'b0; repeat (3) cycle();
    end
    chk("manual_3_pulses", 32'(n_ticks - t0), 32'd3);
    t0 = n_ticks;
    i_step = 1'b1; repeat (20) cycle();
    i_step = 1'b0; repeat (2) cycle();
    chk("manual_held_high", 32'(n_ticks - t0), 32'd1);

    // Loads
    i_seed = 16'h0000; i_load = 1'b1; cycle(); i_load = 1'b0;
    chk("load_zero_seed", 32'(o_lfsr), 32'hACE1);
    i_enable = 1'b1;
    for (int k = 0; k < 8 && m_cnt != STEP_DIV - 1; k++) cycle();
    i_seed = 16'h1234; i_load = 1'b1; cycle(); i_load = 1'b0;
    chk("load_beats_step", 32'(o_lfsr), 32'h1234);
    chk("load_no_tick", 32'(o_step_tick), 32'h0);

    // Scan with latch = 00A5
    i_enable = 1'b0;
    i_seed = 16'h00A5; i_load = 1'b1; cycle(); i_load = 1'b0;
    repeat (3) cycle();
    for (int d = 0; d < 4; d++) visits[d] = 0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      found = 0;
      for (int d = 0; d < 4; d++) begin
        if (anode === ~(4'b0001 << d)) begin
          found = 1; visits[d]++;
          chk("scan_seg", 32'(led), 32'(exp_seg[d]));
          chk("scan_seg_blank", 32'(led_b), 32'(exp_seg_b[d]));
        end
      end
      chk("scan_onehot", 32'(found), 32'd1);
    end
    for (int d = 0; d < 4; d++) chk("scan_slot_len", 32'(visits[d]), 32'd2);

    // Hold freezes the display while the LFSR keeps stepping
    i_enable = 1'b1; i_hold = 1'b1;
    t0 = n_ticks;
    for (int k = 0; k < 16; k++) begin
      cycle();
      for (int d = 0; d < 4; d++)
        if (anode === ~(4'b0001 << d)) chk("hold_seg", 32'(led), 32'(exp_seg[d]));
    end
    chk("hold_lfsr_moved", 32'(o_lfsr != 16'h00A5), 32'h1);
    chk("hold_ticks", 32'(n_ticks - t0), 32'd4);
    i_hold = 1'b0;
    repeat (4) cycle();

    // Random stimulus, including occasional mid-run resets
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(7) == 0) i_enable = ~i_enable;
      i_step = 1'($urandom_range(1));
      i_load = ($urandom_range(19) == 0);
      i_seed = ($urandom_range(3) == 0) ? 16'h0 : 16'($urandom);
      if ($urandom_range(5) == 0) i_hold = ~i_hold;
      reset  = ($urandom_range(99) == 0);
      cycle();
    end
    reset = 1'b0; i_load = 1'b0; i_hold = 1'b0; i_step = 1'b0; i_enable = 1'b1;

    // Full period of the 8-bit, single-digit instance
    cycle(); cycle();
    p_reset = 1'b0;
    p_prev = 8'h01; ph1 = 8'h01; ph2 = 8'h01;
    steps = 0; done = 1'b0;
    for (int k = 0; k < 700 && !done; k++) begin
      cycle();
      chk("p_anode", 32'(p_anode), 32'h0);
      if (k >= 2) chk("p_led", 32'(p_led), 32'(seg_tab[ph2[3:0]]));
      if (p_tick === 1'b1) begin
        steps++;
        chk("p_step", 32'(p_lfsr), lfsr_next(32'(p_prev), 32'hB8, 8));
        chk("p_nonzero", 32'(p_lfsr != 8'h00), 32'h1);
        p_prev = p_lfsr;
        if (p_lfsr == 8'h01) done = 1'b1;
      end
      ph2 = ph1; ph1 = p_lfsr;
    end
    chk("p_period", 32'(steps), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
